// File: rtl/reg4_load_arbiter.sv
// Round-robin arbiter that sequences ld/clear/I of one shared parallel-load register
// among N_REQ requesters, with a post-reset clear pulse and explicit clear requests.
module reg4_load_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 4
) (
    input  logic               clk_i,
    input  logic               clear_n_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] data_i,
    input  logic               clr_req_i,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   ack_o,
    output logic               clr_ack_o,
    output logic               ld_o,
    output logic [W-1:0]       I_o,
    output logic               clear_o,
    output logic               busy_o
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_LOAD,
        S_ACK,
        S_CLR
    } state_t;

    state_t            state_q;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    logic [N_REQ-1:0]  gnt_q;
    logic [N_REQ-1:0]  ack_q;
    logic              clr_ack_q;
    logic              ld_q;
    logic              clear_q;
    logic [W-1:0]      I_q;

    logic              found_d;
    logic [PW-1:0]     win_d;
    logic [W-1:0]      data_d;
    logic [N_REQ-1:0]  gnt_d;

    // Scan upward from ptr_q+1 with wrap; the first set request wins.
    always_comb begin
        found_d = 1'b0;
        win_d   = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            if (!found_d && 1'(req_i >> ((32'(ptr_q) + i) % N_REQ))) begin
                found_d = 1'b1;
                win_d   = PW'((32'(ptr_q) + i) % N_REQ);
            end
        end
        data_d = W'(data_i >> (32'(win_d) * W));
        gnt_d  = {{(N_REQ-1){1'b0}}, 1'b1} << win_d;
    end

    always_ff @(posedge clk_i) begin
        if (!clear_n_i) begin
            state_q   <= S_INIT;
            ptr_q     <= PW'(N_REQ - 1);
            win_q     <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            clr_ack_q <= 1'b0;
            ld_q      <= 1'b0;
            clear_q   <= 1'b0;
            I_q       <= '0;
        end else begin
            case (state_q)
                // clear_q low marks the reset-held cycles; the first released edge raises it.
                S_INIT: begin
                    if (!clear_q) begin
                        clear_q <= 1'b1;
                    end else begin
                        clear_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (clr_req_i) begin
                        clear_q   <= 1'b1;
                        clr_ack_q <= 1'b1;
                        state_q   <= S_CLR;
                    end else if (found_d) begin
                        gnt_q   <= gnt_d;
                        I_q     <= data_d;
                        ld_q    <= 1'b1;
                        win_q   <= win_d;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    ld_q    <= 1'b0;
                    ack_q   <= gnt_q;
                    ptr_q   <= win_q;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    I_q     <= '0;
                    state_q <= S_IDLE;
                end
                S_CLR: begin
                    clear_q   <= 1'b0;
                    clr_ack_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign clr_ack_o = clr_ack_q;
    assign ld_o      = ld_q;
    assign I_o       = I_q;
    assign clear_o   = clear_q;
    assign busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg4_load_arbiter.sv
// Self-checking bench for reg4_load_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level round-robin model.
module tb_reg4_load_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             clear_n = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   data = '0;
    logic             clr_req = 1'b0;
    logic [N-1:0]     gnt_o, ack_o;
    logic             clr_ack_o, ld_o, clear_o, busy_o;
    logic [W-1:0]     I_o;

    int checks = 0;
    int errors = 0;
    int m_ptr  = N - 1;
    int cyc    = 0;
    logic [W-1:0] shreg = '0;

    reg4_load_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk_i(clk), .clear_n_i(clear_n), .req_i(req), .data_i(data),
        .clr_req_i(clr_req), .gnt_o(gnt_o), .ack_o(ack_o), .clr_ack_o(clr_ack_o),
        .ld_o(ld_o), .I_o(I_o), .clear_o(clear_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // The shared register this arbiter drives.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (clear_o)   shreg <= '0;
        else if (ld_o) shreg <= I_o;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int pick(int ptr, logic [N-1:0] mask);
        for (int i = 1; i <= N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] slot(logic [N*W-1:0] d, int k);
        logic [N*W-1:0] t;
        t = d >> (k * W);
        return t[W-1:0];
    endfunction

    task automatic do_reset();
        clear_n = 1'b0; req = '0; clr_req = 1'b0;
        repeat (2) tick();
        clear_n = 1'b1;
        m_ptr = N - 1;
        repeat (2) tick();
    endtask

    // Status vector order: {gnt, ack, ld, clear, clr_ack, busy}
    task automatic test_reset();
        logic [2*N+3:0] st;
        clear_n = 1'b0; req = N'($urandom); clr_req = 1'b1; data = (N*W)'($urandom);
        repeat (2) tick();
        st = {gnt_o, ack_o, ld_o, clear_o, clr_ack_o, busy_o};
        checks++;
        if (st !== {{(2*N){1'b0}}, 4'b0001}) begin
            errors++; $display("FAIL reset_state: got %h expected %h", st, {{(2*N){1'b0}}, 4'b0001});
        end
        checks++;
        if (I_o !== '0) begin errors++; $display("FAIL reset_I: got %h expected 0", I_o); end
        clear_n = 1'b1; req = '0; clr_req = 1'b0; m_ptr = N - 1;
        tick();
        st = {gnt_o, ack_o, ld_o, clear_o, clr_ack_o, busy_o};
        checks++;
        if (st !== {{(2*N){1'b0}}, 4'b0101}) begin
            errors++; $display("FAIL init_pulse: got %h expected %h", st, {{(2*N){1'b0}}, 4'b0101});
        end
        tick();
        st = {gnt_o, ack_o, ld_o, clear_o, clr_ack_o, busy_o};
        checks++;
        if (st !== '0) begin errors++; $display("FAIL init_done: got %h expected 0", st); end
        checks++;
        if (shreg !== '0) begin errors++; $display("FAIL init_reg: got %h expected 0", shreg); end
    endtask

    task automatic test_single();
        int k;
        logic [W-1:0] d;
        for (int rep = 0; rep < 4; rep++) begin
            data = (N*W)'($urandom);
            if (rep == 0) begin k = 2; data[2*W +: W] = 4'hA; end
            else k = $urandom_range(0, N - 1);
            d = slot(data, k);
            req = N'(1) << k;
            tick();
            checks++;
            if ({gnt_o, ld_o, clear_o, busy_o} !== {N'(1) << k, 3'b101}) begin
                errors++; $display("FAIL single_load: gnt=%b ld=%b clear=%b busy=%b expected gnt=%b ld=1",
                                   gnt_o, ld_o, clear_o, busy_o, N'(1) << k);
            end
            checks++;
            if (I_o !== d) begin errors++; $display("FAIL single_I: got %h expected %h", I_o, d); end
            req = '0; data = (N*W)'($urandom);
            tick();
            checks++;
            if ({gnt_o, ack_o, ld_o} !== {N'(1) << k, N'(1) << k, 1'b0}) begin
                errors++; $display("FAIL single_ack: gnt=%b ack=%b ld=%b expected %b", gnt_o, ack_o, ld_o, N'(1) << k);
            end
            checks++;
            if (shreg !== d) begin errors++; $display("FAIL single_reg: got %h expected %h", shreg, d); end
            m_ptr = k;
            tick();
            checks++;
            if ({gnt_o, ack_o, busy_o} !== '0) begin
                errors++; $display("FAIL single_idle: gnt=%b ack=%b busy=%b expected 0", gnt_o, ack_o, busy_o);
            end
        end
    endtask

    task automatic test_all_held();
        int exp_w;
        int prev;
        do_reset();
        data = {4'hC, 4'hD, 4'hE, 4'hF};
        req = '1;
        prev = 0;
        for (int g = 0; g < N; g++) begin
            tick();
            exp_w = pick(m_ptr, req);
            checks++;
            if ({gnt_o, ld_o} !== {N'(1) << exp_w, 1'b1} || gnt_o !== N'(1) << g) begin
                errors++; $display("FAIL rr_order[%0d]: gnt=%b ld=%b expected gnt=%b", g, gnt_o, ld_o, N'(1) << exp_w);
            end
            if (g > 0) begin
                checks++;
                if (cyc - prev !== 3) begin
                    errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", g, cyc - prev);
                end
            end
            prev = cyc;
            tick();
            checks++;
            if (ack_o !== N'(1) << exp_w || shreg !== slot(data, exp_w)) begin
                errors++; $display("FAIL rr_ack[%0d]: ack=%b reg=%h expected ack=%b reg=%h",
                                   g, ack_o, shreg, N'(1) << exp_w, slot(data, exp_w));
            end
            req[exp_w] = 1'b0;
            m_ptr = exp_w;
            tick();
        end
    endtask

    task automatic test_fairness();
        int exp_w;
        int served[N];
        for (int i = 0; i < N; i++) served[i] = 0;
        req = 4'b0101;
        for (int g = 0; g < 6; g++) begin
            tick();
            exp_w = pick(m_ptr, req);
            checks++;
            if (gnt_o !== N'(1) << exp_w) begin
                errors++; $display("FAIL fair_gnt[%0d]: got %b expected %b", g, gnt_o, N'(1) << exp_w);
            end
            for (int i = 0; i < N; i++) if (gnt_o[i]) served[i]++;
            tick();
            m_ptr = exp_w;
            tick();
        end
        checks++;
        if (served[0] !== 3 || served[2] !== 3) begin
            errors++; $display("FAIL fair_count: req0=%0d req2=%0d expected 3 and 3", served[0], served[2]);
        end
        req = '0;
    endtask

    task automatic test_clr_priority();
        int exp_w;
        logic [2*N+3:0] st;
        clr_req = 1'b1; req = 4'b0001; data = (N*W)'($urandom);
        tick();
        st = {gnt_o, ack_o, ld_o, clear_o, clr_ack_o, busy_o};
        checks++;
        if (st !== {{(2*N){1'b0}}, 4'b0111}) begin
            errors++; $display("FAIL clr_first: got %h expected %h", st, {{(2*N){1'b0}}, 4'b0111});
        end
        clr_req = 1'b0;
        tick();
        checks++;
        if ({clear_o, clr_ack_o, busy_o, ld_o} !== 4'b0000 || shreg !== '0) begin
            errors++; $display("FAIL clr_done: clear=%b clr_ack=%b busy=%b reg=%h expected 0",
                               clear_o, clr_ack_o, busy_o, shreg);
        end
        tick();
        exp_w = pick(m_ptr, req);
        checks++;
        if ({gnt_o, ld_o} !== {N'(1) << exp_w, 1'b1}) begin
            errors++; $display("FAIL clr_then_load: gnt=%b ld=%b expected %b", gnt_o, ld_o, N'(1) << exp_w);
        end
        tick();
        req = '0; m_ptr = exp_w;
        tick();
        // clear request raised during a load must be served afterwards
        req = 4'b0010;
        tick();
        clr_req = 1'b1; req = '0;
        tick();
        checks++;
        if (clear_o !== 1'b0 || ack_o !== 4'b0010) begin
            errors++; $display("FAIL clr_during_load: clear=%b ack=%b expected clear=0 ack=0010", clear_o, ack_o);
        end
        m_ptr = 1;
        tick();
        tick();
        checks++;
        if ({clear_o, clr_ack_o, ld_o} !== 3'b110) begin
            errors++; $display("FAIL clr_pending: clear=%b clr_ack=%b ld=%b expected 1 1 0", clear_o, clr_ack_o, ld_o);
        end
        clr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_load();
        logic [2*N+3:0] st;
        req = 4'b0010; data = (N*W)'($urandom);
        tick();
        clear_n = 1'b0;
        tick();
        st = {gnt_o, ack_o, ld_o, clear_o, clr_ack_o, busy_o};
        checks++;
        if (st !== {{(2*N){1'b0}}, 4'b0001}) begin
            errors++; $display("FAIL abort_load: got %h expected %h", st, {{(2*N){1'b0}}, 4'b0001});
        end
        tick();
        checks++;
        if (ack_o !== '0) begin errors++; $display("FAIL abort_noack: got %b expected 0", ack_o); end
        clear_n = 1'b1; req = '1; m_ptr = N - 1;
        tick();
        checks++;
        if ({clear_o, ld_o, busy_o} !== 3'b101) begin
            errors++; $display("FAIL abort_init: clear=%b ld=%b busy=%b expected 1 0 1", clear_o, ld_o, busy_o);
        end
        tick();
        tick();
        checks++;
        if (gnt_o !== N'(1) << pick(m_ptr, req) || shreg !== '0) begin
            errors++; $display("FAIL abort_restart: gnt=%b reg=%h expected %b reg 0", gnt_o, shreg, N'(1) << pick(m_ptr, req));
        end
        m_ptr = pick(m_ptr, req);
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_random();
        int exp_w;
        logic [W-1:0] d;
        for (int t = 0; t < 60; t++) begin
            checks++;
            if (busy_o !== 1'b0) begin errors++; $display("FAIL rnd_idle[%0d]: busy=%b expected 0", t, busy_o); end
            req = req | N'($urandom_range(0, 15) & $urandom_range(0, 15));
            data = (N*W)'($urandom);
            clr_req = ($urandom_range(0, 4) == 0);
            tick();
            if (clr_req) begin
                checks++;
                if ({gnt_o, ld_o, clear_o, clr_ack_o} !== {N'(0), 3'b011}) begin
                    errors++; $display("FAIL rnd_clr[%0d]: gnt=%b ld=%b clear=%b clr_ack=%b expected 0 0 1 1",
                                       t, gnt_o, ld_o, clear_o, clr_ack_o);
                end
                clr_req = 1'b0;
                tick();
            end else if (req == '0) begin
                checks++;
                if ({gnt_o, ld_o, busy_o} !== '0) begin
                    errors++; $display("FAIL rnd_noreq[%0d]: gnt=%b ld=%b busy=%b expected 0", t, gnt_o, ld_o, busy_o);
                end
            end else begin
                exp_w = pick(m_ptr, req);
                d = slot(data, exp_w);
                checks++;
                if ({gnt_o, ld_o, clear_o} !== {N'(1) << exp_w, 2'b10} || I_o !== d) begin
                    errors++; $display("FAIL rnd_load[%0d]: gnt=%b ld=%b I=%h expected gnt=%b ld=1 I=%h",
                                       t, gnt_o, ld_o, I_o, N'(1) << exp_w, d);
                end
                data = (N*W)'($urandom);
                tick();
                checks++;
                if (ack_o !== N'(1) << exp_w || shreg !== d) begin
                    errors++; $display("FAIL rnd_ack[%0d]: ack=%b reg=%h expected ack=%b reg=%h",
                                       t, ack_o, shreg, N'(1) << exp_w, d);
                end
                req[exp_w] = 1'b0;
                m_ptr = exp_w;
                tick();
            end
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_all_held();
        test_fairness();
        test_clr_priority();
        test_reset_mid_load();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
